eva_mem_req_ctrl: RTL and testbench

Request front end that sits directly upstream of the `EVA_MEM_WRAP` memory model in the testbench. Accepts a valid/ready request stream (reads and masked writes), drives the memory's `rd`/`we`/`addr`/`wdata` pins from registers, and captures `rdata` at the memory's fixed one-cycle read latency into a response FIFO with valid/ready backpressure. Credit-based flow control guarantees the response FIFO never overflows.

---
 rtl/eva_mem_req_ctrl.sv | 114 +++++++++++
 tb/tb_eva_mem_req_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eva_mem_req_ctrl.sv
// eva_mem_req_ctrl: valid/ready request front end for the EVA_MEM_WRAP memory with a credit-protected response FIFO
//
// Optional feature: define EVA_MEM_WR_ACK_EN so every accepted write (mask 0 included) returns one
// response entry with rsp_wr=1 and rsp_rdata=0, in order with reads. Undefined: writes are silent.
//
// Ports:
//   clk, rst_n                      clock; asynchronous active-low reset
//   req_valid/req_ready             request handshake (accept when both high)
//   req_wr, req_addr, req_wdata     request kind, address, write data
//   req_mask                        per-lane write enable (ignored for reads)
//   rsp_valid/rsp_ready             response FIFO head handshake (pop when both high)
//   rsp_rdata, rsp_wr               head read data, head-is-write-ack flag
//   mem_rd, mem_we, mem_addr,       registered memory pins
//   mem_wdata
//   mem_rdata                       memory read data, valid one cycle after the sampling edge
module eva_mem_req_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MASKBITS  = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [31:0]         req_addr,
    input  logic [WIDTH-1:0]    req_wdata,
    input  logic [MASKBITS-1:0] req_mask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_rdata,
    output logic                rsp_wr,
    output logic                mem_rd,
    output logic [MASKBITS-1:0] mem_we,
    output logic [31:0]         mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [CW-1:0]    cnt;
    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] dmem [RSP_DEPTH];
    logic             rd_pend;
    logic             acc, pop, push, inc;
    logic [WIDTH-1:0] push_data;

    // Credits cover issue stage, capture stage and FIFO, so a push never meets a full FIFO.
    assign req_ready = cnt < CW'(RSP_DEPTH);
    assign acc       = req_valid & req_ready;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign rsp_valid = wp != rp;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = rsp_valid ? dmem[rp[AW-1:0]] : '0;

`ifdef EVA_MEM_WR_ACK_EN
    logic wack_iss, wack_pend;
    logic wmem [RSP_DEPTH];

    assign inc       = acc;
    assign push      = rd_pend | wack_pend;
    assign push_data = rd_pend ? mem_rdata : '0;
    assign rsp_wr    = rsp_valid & wmem[rp[AW-1:0]];

    // Write acks travel through the same two stages as reads to keep responses in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wack_iss  <= 1'b0;
            wack_pend <= 1'b0;
        end else begin
            wack_iss  <= acc & req_wr;
            wack_pend <= wack_iss;
        end
    end

    always_ff @(posedge clk) begin
        if (push) wmem[wp[AW-1:0]] <= wack_pend;
    end
`else
    assign inc       = acc & ~req_wr;
    assign push      = rd_pend;
    assign push_data = mem_rdata;
    assign rsp_wr    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_pend   <= 1'b0;
            cnt       <= '0;
            wp        <= '0;
            rp        <= '0;
        end else begin
            mem_rd  <= acc & ~req_wr;
            mem_we  <= (acc & req_wr) ? req_mask : '0;
            if (acc) mem_addr <= req_addr;
            if (acc & req_wr) mem_wdata <= req_wdata;
            // Set on the edge the memory samples mem_rd; data is captured on the next edge.
            rd_pend <= mem_rd;
            cnt     <= cnt + CW'(inc) - CW'(pop);
            if (push) wp <= wp + PTR_ONE;
            if (pop) rp <= rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) dmem[wp[AW-1:0]] <= push_data;
    end
endmodule

// File: tb/tb_eva_mem_req_ctrl.sv
// tb_eva_mem_req_ctrl: directed self-checking bench for eva_mem_req_ctrl with a one-cycle-latency memory model
module tb_eva_mem_req_ctrl;
    localparam int WIDTH     = 32;
    localparam int MASKBITS  = 1;
    localparam int RSP_DEPTH = 4;
`ifdef EVA_MEM_WR_ACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid, req_ready, req_wr;
    logic [31:0]         req_addr;
    logic [WIDTH-1:0]    req_wdata;
    logic [MASKBITS-1:0] req_mask;
    logic                rsp_valid, rsp_ready, rsp_wr;
    logic [WIDTH-1:0]    rsp_rdata;
    logic                mem_rd;
    logic [MASKBITS-1:0] mem_we;
    logic [31:0]         mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    int checks = 0;
    int errors = 0;
    int mcnt = 0;
    logic [31:0] mem_arr [256];

    always #5 clk = ~clk;

    eva_mem_req_ctrl #(.WIDTH(WIDTH), .MASKBITS(MASKBITS), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_wr(rsp_wr),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory model: word write on we, read data valid one cycle after the sampling edge.
    always @(posedge clk) begin
        if (mem_we[0]) mem_arr[mem_addr[7:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem_arr[mem_addr[7:0]];
    end

    // Credit model: outstanding responses never exceed the FIFO depth and gate req_ready.
    always @(posedge clk) begin
        if (!rst_n) mcnt <= 0;
        else begin
            checks++;
            if (req_ready !== (mcnt < RSP_DEPTH) || mcnt > RSP_DEPTH) begin
                errors++;
                $display("FAIL credit: req_ready=%0b model_cnt=%0d", req_ready, mcnt);
            end
            mcnt <= mcnt + ((req_valid && req_ready && (WACK || !req_wr)) ? 1 : 0)
                         - ((rsp_valid && rsp_ready) ? 1 : 0);
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_wr, mem_rd, mem_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, rsp_valid, rsp_wr, mem_rd, mem_we});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        checks++;
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({mem_rd, mem_we} !== 2'b00) begin
                errors++;
                $display("FAIL idle_pins: rd/we got %b want 00", {mem_rd, mem_we});
            end
        end
    endtask

    task automatic test_write_read;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_mask = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_we} !== 2'b01) begin errors++; $display("FAIL wr_issue: rd/we got %b want 01", {mem_rd, mem_we}); end
        checks++;
        if (mem_addr !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", mem_addr); end
        checks++;
        if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h want deadbeef", mem_wdata); end
        req_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_we} !== 2'b10) begin errors++; $display("FAIL rd_issue: rd/we got %b want 10", {mem_rd, mem_we}); end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_arr[16] !== 32'hDEADBEEF) begin errors++; $display("FAIL mem_written: got %h want deadbeef", mem_arr[16]); end
`ifdef EVA_MEM_WR_ACK_EN
        checks++;
        if ({rsp_valid, rsp_wr} !== 2'b11 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_ack_rsp: valid/wr got %b rdata %h want 11 0", {rsp_valid, rsp_wr}, rsp_rdata);
        end
        rsp_ready = 1'b1;
`else
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early: rsp_valid got %b want 0", rsp_valid); end
`endif
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_wr} !== 2'b10) begin errors++; $display("FAIL rd_rsp: valid/wr got %b want 10", {rsp_valid, rsp_wr}); end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pop: rsp_valid got %b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int   n_acc, got;
        logic acc_now;
        rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0; n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            acc_now = req_valid & req_ready;
            @(negedge clk);
            if (acc_now) begin n_acc++; req_addr = 32'(n_acc); end
        end
        checks++;
        if (n_acc !== 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", n_acc); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000000) begin
            errors++;
            $display("FAIL bp_head: valid %b rdata %h want 1 a5000000", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1; got = 0;
        for (int c = 0; c < 16; c++) begin
            acc_now = req_valid & req_ready;
            if (c == 0) begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_held: got %b want 0", req_ready); end
            end
            if (c == 1) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b want 1", req_ready); end
            end
            if (rsp_valid) begin
                checks++;
                if (rsp_rdata !== 32'hA5000000 + 32'(got) || rsp_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_%0d: rdata %h wr %b want %h 0", got, rsp_rdata, rsp_wr, 32'hA5000000 + 32'(got));
                end
                got++;
            end
            @(negedge clk);
            if (acc_now) begin
                n_acc++;
                if (n_acc < 6) req_addr = 32'(n_acc);
                else req_valid = 1'b0;
            end
        end
        checks++;
        if (got !== 6 || n_acc !== 6) begin errors++; $display("FAIL drain_count: got %0d rsp %0d acc want 6 6", got, n_acc); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: rsp_valid %b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0;
        @(negedge clk); req_addr = 32'h1;
        @(negedge clk); req_addr = 32'h2;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: rsp_valid %b want 1", rsp_valid); end
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, mem_rd} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset: ready/valid/rd got %b want 100", {req_ready, rsp_valid, mem_rd});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost: rsp_valid %b want 0", rsp_valid); end
        end
        req_valid = 1'b1; req_addr = 32'h3;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_early: rsp_valid %b want 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000003) begin
            errors++;
            $display("FAIL mid_read: valid %b rdata %h want 1 a5000003", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_pop: rsp_valid %b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_wr_ack;
        logic [31:0] exp_d [3];
        logic        exp_w [3];
        int          n_exp, got;
`ifdef EVA_MEM_WR_ACK_EN
        exp_d[0] = 32'hA5000001; exp_d[1] = 32'h0;        exp_d[2] = 32'hA5000003;
        exp_w[0] = 1'b0;         exp_w[1] = 1'b1;         exp_w[2] = 1'b0;
        n_exp = 3;
`else
        exp_d[0] = 32'hA5000001; exp_d[1] = 32'hA5000003; exp_d[2] = 32'h0;
        exp_w[0] = 1'b0;         exp_w[1] = 1'b0;         exp_w[2] = 1'b0;
        n_exp = 2;
`endif
        rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h1;
        @(negedge clk); req_wr = 1'b1; req_addr = 32'h2; req_mask = 1'b0; req_wdata = 32'hFFFFFFFF;
        @(negedge clk); req_wr = 1'b0; req_addr = 32'h3;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (mem_we !== 1'b0) begin errors++; $display("FAIL mask0_we_%0d: got %b want 0", c, mem_we); end
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if (mem_arr[2] !== 32'hA5000002) begin errors++; $display("FAIL mask0_mem: got %h want a5000002", mem_arr[2]); end
        rsp_ready = 1'b1; got = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) begin
                checks++;
                if (got >= 3 || rsp_rdata !== exp_d[got] || rsp_wr !== exp_w[got]) begin
                    errors++;
                    $display("FAIL ack_rsp_%0d: rdata %h wr %b", got, rsp_rdata, rsp_wr);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== n_exp) begin errors++; $display("FAIL ack_count: got %0d want %0d", got, n_exp); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_mask = 1'b0; rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA5000000 + 32'(i);
        test_reset;
        test_write_read;
        test_backpressure;
        test_reset_mid;
        test_wr_ack;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
